lv_efuse_load_ctrl: RTL
=======================

// Module: lv_efuse_load_ctrl
// PURPOSE
//  Hardware efuse loader directly downstream of the LV control FSM.
//  - Consumes the efuse load request and returns a one-cycle load-done pulse.
//  - Sequences the efuse macro read (address/rden/strobe timing) and writes every word into the register bank.
//  - Verifies a checksum word and drives the efuse-valid flag that the FSM uses to choose TEST_ST or normal start.
// PARAMETERS
//  EFUSE_WORD_NUM  8  words in efuse; word N-1 is the checksum word
//  EFUSE_DATA_W    8  efuse word width
//  EFUSE_ADDR_W    3  word address width, = $clog2(EFUSE_WORD_NUM)
//  SETUP_CYC       2  cycles address/rden stable before strobe, >=1
//  RD_STRB_CYC     4  strobe high cycles, >=1
// PORTS
//  i_clk               in   1              clock
//  i_rst_n             in   1              async reset, active low
//  i_efuse_load_req    in   1              load request, level, from ctrl FSM
//  i_load_abort        in   1              sync abort (FSM leaving to PWR_DWN_ST)
//  o_efuse_load_done   out  1              1-cycle pulse, load complete
//  o_efuse_busy        out  1              high from accept until DONE
//  o_efuse_addr        out  EFUSE_ADDR_W   macro word address
//  o_efuse_rden        out  1              macro read enable
//  o_efuse_strb        out  1              macro read strobe
//  i_efuse_rdata       in   EFUSE_DATA_W   macro read data, valid in CAPT
//  o_reg_efuse_wr_en   out  1              reg bank write pulse
//  o_reg_efuse_waddr   out  EFUSE_ADDR_W   reg bank word index
//  o_reg_efuse_wdata   out  EFUSE_DATA_W   reg bank data
//  o_reg_efuse_vld     out  1              checksum OK, sticky until next load
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; counters 0. All outputs are registered.
//  State machine:
//  - IDLE: on i_efuse_load_req=1, go to SETUP. Clear o_reg_efuse_vld. Set addr=0, busy=1, and seed chk_acc=8'hA5.
//  - SETUP: rden=1. Stays SETUP_CYC cycles, then goes to STRB.
//  - STRB: rden=1, strb=1 for RD_STRB_CYC cycles, then goes to CAPT.
//  - CAPT (1 cycle): strb=0, rden=1. Sample i_efuse_rdata. Pulse wr_en with waddr=addr, wdata=rdata.
//    - If addr < N-1: chk_acc ^= rdata; addr++; go to SETUP.
//    - Else: vld <= (rdata == chk_acc); done pulse; go to DONE.
//  - DONE: rden=0, busy=0. Go to IDLE only once i_efuse_load_req=0. This prevents a relaunch while the
//    FSM's registered request is still high (4-phase handshake).
//  Timing: with req sampled high at edge 0, done is high in cycle N*(SETUP_CYC+RD_STRB_CYC+1)+1.
//    o_reg_efuse_vld is valid in the same cycle as done and holds afterwards.
//  Address: wraps never; the counter stops at N-1. Unprogrammed efuse (all 0) fails the check because of the 8'hA5 seed.
//  Abort: i_load_abort in any state except IDLE has priority.
//    - Next cycle: IDLE; rden/strb/wr_en/busy=0; no done pulse; vld stays 0.
//    - A reg write already registered this cycle still completes.
//  Request dropping mid-load: ignored; the load runs to DONE.
//  Abort and done in the same cycle: abort wins; done is suppressed.
//  Async reset mid-load: immediate return to IDLE with all outputs 0.
// CONFIGURATION
//  `EFUSE_DBL_RD_EN defined:
//  - Each word is read twice: SETUP->STRB->CAPT(store)->STRB->CAPT(compare).
//  - Reg write occurs on the second CAPT only.
//  - Any mismatch sets a sticky dbl_err; at completion vld = chk_ok & ~dbl_err.
//  - Per-word cost is SETUP_CYC+2*RD_STRB_CYC+2.
//  Not defined: single read, and vld = chk_ok only.
// STRUCTURE
//  Add to shared lv_param.svh: EFUSE_LD_ST_W, state encodings (IDLE, SETUP, STRB, CAPT, DONE),
//  EFUSE_CHK_SEED=8'hA5, EFUSE_WORD_NUM/DATA_W/ADDR_W defaults.
//  No sub-module: one FSM, one phase-cycle counter ($clog2(max(SETUP_CYC,RD_STRB_CYC))+1 bits), one word counter.
// TESTING
//  1. Words 01..07, word7 = A5^01^..^07 = A5 -> 7 wr_en pulses + 1 on word7; done at cycle 57; vld=1.
//  2. Same data with word7=00 -> done at 57; vld=0; all 8 words still written.
//  3. All-zero efuse -> vld=0. Req held high 3 cycles after done -> no second load starts; busy=0.
//  4. i_load_abort in word 3 STRB -> next cycle IDLE, strb=0, no done, vld=0. New req -> full load, done at 57.
//  5. i_rst_n low during CAPT of word 5 -> all outputs 0 asynchronously. After release, req -> clean load from addr 0.
//  6. EFUSE_DBL_RD_EN, word 2 returns 33 then 35 -> done at cycle 97; vld=0. Identical reads -> vld=1.

Source files
------------

// File: rtl/lv_efuse_load_ctrl_pkg.sv
// rtl/lv_efuse_load_ctrl_pkg.sv - shared efuse loader parameters, state encodings and helpers
package lv_efuse_load_ctrl_pkg;

  localparam int EFUSE_WORD_NUM_DFLT = 8;
  localparam int EFUSE_DATA_W_DFLT   = 8;
  localparam int EFUSE_ADDR_W_DFLT   = 3;
  localparam int EFUSE_LD_ST_W       = 3;

  // Non-zero seed so that a blank (all-zero) efuse can never pass the checksum.
  localparam logic [7:0] EFUSE_CHK_SEED = 8'hA5;

  typedef enum logic [EFUSE_LD_ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_STRB  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } efuse_ld_st_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lv_efuse_load_ctrl.sv
// rtl/lv_efuse_load_ctrl.sv - efuse macro read sequencer and checksum checker (option: EFUSE_DBL_RD_EN)
module lv_efuse_load_ctrl
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_WORD_NUM = EFUSE_WORD_NUM_DFLT,
  parameter int EFUSE_DATA_W   = EFUSE_DATA_W_DFLT,
  parameter int EFUSE_ADDR_W   = EFUSE_ADDR_W_DFLT,
  parameter int SETUP_CYC      = 2,
  parameter int RD_STRB_CYC    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  input  logic                    i_load_abort,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_busy,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  output logic                    o_efuse_rden,
  output logic                    o_efuse_strb,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
  output logic                    o_reg_efuse_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_reg_efuse_waddr,
  output logic [EFUSE_DATA_W-1:0] o_reg_efuse_wdata,
  output logic                    o_reg_efuse_vld
);

  localparam int CNT_W = $clog2(max_int(SETUP_CYC, RD_STRB_CYC)) + 1;
  localparam logic [CNT_W-1:0]        SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]        STRB_LAST  = CNT_W'(RD_STRB_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_ADDR  = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
  localparam logic [EFUSE_DATA_W-1:0] CHK_SEED   = EFUSE_DATA_W'(EFUSE_CHK_SEED);

  efuse_ld_st_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [EFUSE_DATA_W-1:0] chk_q, chk_d;
  logic [EFUSE_ADDR_W-1:0] addr_d;
  logic                    rden_d, strb_d, busy_d, done_d, vld_d, wr_en_d;
  logic [EFUSE_ADDR_W-1:0] waddr_d;
  logic [EFUSE_DATA_W-1:0] wdata_d;
  logic                    word_end;
`ifdef EFUSE_DBL_RD_EN
  logic                    pass_q, pass_d;
  logic [EFUSE_DATA_W-1:0] first_q, first_d;
  logic                    err_q, err_d;
  logic                    err_now;
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    addr_d   = o_efuse_addr;
    wr_en_d  = 1'b0;
    waddr_d  = o_reg_efuse_waddr;
    wdata_d  = o_reg_efuse_wdata;
    done_d   = 1'b0;
    vld_d    = o_reg_efuse_vld;
    word_end = 1'b0;
`ifdef EFUSE_DBL_RD_EN
    pass_d   = pass_q;
    first_d  = first_q;
    err_d    = err_q;
    err_now  = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_efuse_load_req) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          addr_d  = '0;
          chk_d   = CHK_SEED;
          vld_d   = 1'b0;
`ifdef EFUSE_DBL_RD_EN
          pass_d  = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_STRB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STRB: begin
        if (cnt_q == STRB_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPT: begin
`ifdef EFUSE_DBL_RD_EN
        // First capture only stores the word; the second one compares and commits it.
        if (!pass_q) begin
          pass_d  = 1'b1;
          first_d = i_efuse_rdata;
          state_d = ST_STRB;
        end else begin
          pass_d   = 1'b0;
          err_now  = err_q | (i_efuse_rdata != first_q);
          err_d    = err_now;
          word_end = 1'b1;
        end
`else
        word_end = 1'b1;
`endif
        if (word_end) begin
          wr_en_d = 1'b1;
          waddr_d = o_efuse_addr;
          wdata_d = i_efuse_rdata;
          if (o_efuse_addr != LAST_ADDR) begin
            chk_d   = chk_q ^ i_efuse_rdata;
            addr_d  = o_efuse_addr + 1'b1;
            state_d = ST_SETUP;
          end else begin
`ifdef EFUSE_DBL_RD_EN
            vld_d   = (i_efuse_rdata == chk_q) & ~err_now;
`else
            vld_d   = (i_efuse_rdata == chk_q);
`endif
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Wait for the request to drop so a still-high level cannot relaunch the load.
        if (!i_efuse_load_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a completing CAPT.
    if (i_load_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      vld_d   = o_reg_efuse_vld;
    end

    rden_d = (state_d == ST_SETUP) || (state_d == ST_STRB) || (state_d == ST_CAPT);
    strb_d = (state_d == ST_STRB);
    busy_d = rden_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      chk_q             <= '0;
      o_efuse_addr      <= '0;
      o_efuse_rden      <= 1'b0;
      o_efuse_strb      <= 1'b0;
      o_efuse_busy      <= 1'b0;
      o_efuse_load_done <= 1'b0;
      o_reg_efuse_wr_en <= 1'b0;
      o_reg_efuse_waddr <= '0;
      o_reg_efuse_wdata <= '0;
      o_reg_efuse_vld   <= 1'b0;
`ifdef EFUSE_DBL_RD_EN
      pass_q            <= 1'b0;
      first_q           <= '0;
      err_q             <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      chk_q             <= chk_d;
      o_efuse_addr      <= addr_d;
      o_efuse_rden      <= rden_d;
      o_efuse_strb      <= strb_d;
      o_efuse_busy      <= busy_d;
      o_efuse_load_done <= done_d;
      o_reg_efuse_wr_en <= wr_en_d;
      o_reg_efuse_waddr <= waddr_d;
      o_reg_efuse_wdata <= wdata_d;
      o_reg_efuse_vld   <= vld_d;
`ifdef EFUSE_DBL_RD_EN
      pass_q            <= pass_d;
      first_q           <= first_d;
      err_q             <= err_d;
`endif
    end
  end

endmodule
